// File: rtl/pps_spi_readout.sv
// SPI mode-0 slave that returns {stale, frame count, PPS count} and receives a command byte.
// The asynchronous PPS count is snapshotted only after it has held the same value for two cycles.
module pps_spi_readout #(
    parameter int          CNT_W       = 24,
    parameter int          CMD_W       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  CLR_CMD     = 8'hC3
) (
    input  logic             mcu_clko,
    input  logic             cpld_rst,
    input  logic [CNT_W-1:0] pps_cnt,
    input  logic             spi_sclk,
    input  logic             spi_csn,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_oe,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_valid,
    output logic             cnt_clr,
    output logic             frame_done
);
    localparam int FRAME = CMD_W + CNT_W;
    localparam int BC_W  = $clog2(FRAME + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync_reg, csn_sync_reg, mosi_sync_reg;
    logic                   sclk_prev_reg, csn_prev_reg;
    logic [CNT_W-1:0]       s1_reg, s2_reg, stable_q_reg;
    logic [FRAME-1:0]       tx_sr_reg;
    logic [CMD_W-2:0]       rx_sr_reg;
    logic [BC_W-1:0]        bit_cnt_reg;
    logic [CMD_W-2:0]       fcnt_reg;
    logic [CMD_W-1:0]       cmd_reg;
    logic                   spi_oe_reg, cmd_valid_reg, cnt_clr_reg, frame_done_reg;

    logic                   sclk_rise, sclk_fall, csn_rise, csn_fall, mosi_bit, stale;
    logic                   bit_inc, cmd_hit;
    logic [BC_W-1:0]        bit_cnt_next;
    logic [CMD_W-1:0]       cmd_rx, cmd_cur;

    assign sclk_rise = sclk_sync_reg[SYNC_STAGES-1] & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_sync_reg[SYNC_STAGES-1] & sclk_prev_reg;
    assign csn_rise  = csn_sync_reg[SYNC_STAGES-1] & ~csn_prev_reg;
    assign csn_fall  = ~csn_sync_reg[SYNC_STAGES-1] & csn_prev_reg;
    assign mosi_bit  = mosi_sync_reg[SYNC_STAGES-1];
    assign stale     = (s1_reg != s2_reg);

    // A CSN rise coinciding with an SCLK edge sees the count/command after that edge.
    assign bit_inc      = sclk_rise && (bit_cnt_reg != BC_W'(FRAME));
    assign bit_cnt_next = bit_cnt_reg + BC_W'(bit_inc);
    assign cmd_hit      = sclk_rise && (bit_cnt_reg == BC_W'(CMD_W - 1));
    assign cmd_rx       = {rx_sr_reg, mosi_bit};
    assign cmd_cur      = cmd_hit ? cmd_rx : cmd_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (csn_fall) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (csn_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mcu_clko or posedge cpld_rst) begin
        if (cpld_rst) begin
            state_reg      <= IDLE;
            sclk_sync_reg  <= '0;
            csn_sync_reg   <= '0;
            mosi_sync_reg  <= '0;
            sclk_prev_reg  <= 1'b0;
            csn_prev_reg   <= 1'b0;
            s1_reg         <= '0;
            s2_reg         <= '0;
            stable_q_reg   <= '0;
            tx_sr_reg      <= '0;
            rx_sr_reg      <= '0;
            bit_cnt_reg    <= '0;
            fcnt_reg       <= '0;
            cmd_reg        <= '0;
            spi_oe_reg     <= 1'b0;
            cmd_valid_reg  <= 1'b0;
            cnt_clr_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
            csn_sync_reg   <= {csn_sync_reg[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_reg  <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_reg  <= sclk_sync_reg[SYNC_STAGES-1];
            csn_prev_reg   <= csn_sync_reg[SYNC_STAGES-1];
            s1_reg         <= pps_cnt;
            s2_reg         <= s1_reg;
            if (s1_reg == s2_reg)
                stable_q_reg <= s2_reg;
            cmd_valid_reg  <= 1'b0;
            cnt_clr_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                LOAD: begin
                    tx_sr_reg   <= {stale, fcnt_reg, stable_q_reg};
                    bit_cnt_reg <= '0;
                    rx_sr_reg   <= '0;
                    spi_oe_reg  <= 1'b1;
                end
                SHIFT: begin
                    if (bit_inc) begin
                        rx_sr_reg   <= {rx_sr_reg[CMD_W-3:0], mosi_bit};
                        bit_cnt_reg <= bit_cnt_next;
                    end
                    if (cmd_hit) begin
                        cmd_reg       <= cmd_rx;
                        cmd_valid_reg <= 1'b1;
                    end
                    if (sclk_fall)
                        tx_sr_reg <= {tx_sr_reg[FRAME-2:0], 1'b0};
                    if (csn_rise) begin
                        spi_oe_reg <= 1'b0;
                        if (bit_cnt_next == BC_W'(FRAME)) begin
                            frame_done_reg <= 1'b1;
                            fcnt_reg       <= fcnt_reg + 1'b1;
                            cnt_clr_reg    <= (cmd_cur == CMD_W'(CLR_CMD));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign spi_miso   = spi_oe_reg & tx_sr_reg[FRAME-1];
    assign spi_oe     = spi_oe_reg;
    assign cmd        = cmd_reg;
    assign cmd_valid  = cmd_valid_reg;
    assign cnt_clr    = cnt_clr_reg;
    assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_pps_spi_readout.sv
// Scoreboard bench: stimulus pushes expected frames/commands, monitors pop and compare on DUT activity.
module tb_pps_spi_readout;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pps_cnt;
    logic        sclk, csn, mosi;
    logic        miso, oe, cmd_valid, cnt_clr, frame_done;
    logic [7:0]  cmd;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] word;
        int          nbits;
    } fexp_t;

    fexp_t       fexp_q[$];
    logic [7:0]  cmd_q[$];
    logic        fd_q[$];     // one entry per expected frame_done, value = expected cnt_clr

    logic [31:0] mon_sr;
    int          mon_n;

    pps_spi_readout dut (
        .mcu_clko   (clk),
        .cpld_rst   (rst),
        .pps_cnt    (pps_cnt),
        .spi_sclk   (sclk),
        .spi_csn    (csn),
        .spi_mosi   (mosi),
        .spi_miso   (miso),
        .spi_oe     (oe),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cnt_clr    (cnt_clr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else
            $display("ok   %s: %h at %0t", name, act, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 8) ? b[7 - i] : 1'b0;
            tick(8);
            sclk = 1'b1;
            tick(8);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] mo, input int nbits, input logic [31:0] exp_word);
        fexp_t e;
        e.word  = exp_word;
        e.nbits = nbits;
        fexp_q.push_back(e);
        if (nbits >= 8) cmd_q.push_back(mo);
        if (nbits == 32) fd_q.push_back(mo == 8'hC3);
        csn = 1'b0;
        tick(10);
        spi_bits(mo, nbits);
        tick(8);
        csn = 1'b1;
        tick(12);
    endtask

    // MISO sampled by the master on SCLK rising edges
    always @(negedge csn) begin
        mon_sr = '0;
        mon_n  = 0;
    end
    always @(posedge sclk) begin
        mon_sr = {mon_sr[30:0], miso};
        mon_n++;
    end
    always @(posedge csn) begin
        if (mon_n > 0) begin
            if (fexp_q.size() == 0)
                check("miso_unexpected_frame", 32'(mon_n), 32'd0);
            else begin
                fexp_t e;
                e = fexp_q.pop_front();
                check("miso_nbits", 32'(mon_n), 32'(e.nbits));
                check("miso_word", mon_sr, e.word >> (32 - e.nbits));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                if (cmd_q.size() == 0)
                    check("cmd_valid_unexpected", 32'(cmd_valid), 32'd0);
                else
                    check("cmd", 32'(cmd), 32'(cmd_q.pop_front()));
            end
            if (frame_done) begin
                if (fd_q.size() == 0)
                    check("frame_done_unexpected", 32'(frame_done), 32'd0);
                else
                    check("cnt_clr_at_frame_done", 32'(cnt_clr), 32'(fd_q.pop_front()));
            end else if (cnt_clr)
                check("cnt_clr_without_frame_done", 32'(cnt_clr), 32'd0);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; csn = 1'b0; sclk = 1'b0; mosi = 1'b0;
        pps_cnt = 24'h00ABCD;
        mon_sr = '0; mon_n = 0;
        tick(5);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_pulses", {29'd0, cmd_valid, cnt_clr, frame_done}, 32'd0);

        // CSN already low at reset release: no frame may start
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(5);
            check("csn_low_at_release_oe", 32'(oe), 32'd0);
        end
        csn = 1'b1;
        tick(10);

        frame(8'h00, 32, 32'h0000ABCD);
        frame(8'hC3, 32, 32'h0100ABCD);

        // Count toggling through LOAD: stale flag set, last stable value sent
        pps_cnt = 24'h123456;
        tick(10);
        begin
            fexp_t e;
            e.word = 32'h82123456; e.nbits = 32;
            fexp_q.push_back(e);
            cmd_q.push_back(8'h00);
            fd_q.push_back(1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            tick(1);
            pps_cnt = i[0] ? 24'h111111 : 24'h222222;
            if (i == 10) csn = 1'b0;
        end
        pps_cnt = 24'h123456;
        tick(2);
        spi_bits(8'h00, 32);
        tick(8);
        csn = 1'b1;
        tick(12);

        // Aborted after 12 bits with the clear command: no clear, fcnt kept
        frame(8'hC3, 12, 32'h03123456);
        frame(8'h00, 32, 32'h03123456);

        // Reset in the middle of a frame
        pps_cnt = 24'h0F0F0F;
        tick(10);
        begin
            fexp_t e;
            e.word = 32'h040F0F0F; e.nbits = 20;
            fexp_q.push_back(e);
            cmd_q.push_back(8'h00);
        end
        csn = 1'b0;
        tick(10);
        spi_bits(8'h00, 20);
        tick(4);
        check("oe_before_reset", 32'(oe), 32'd1);
        rst = 1'b1;
        #1;
        check("oe_async_drop", 32'(oe), 32'd0);
        tick(3);
        csn = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(12);
        frame(8'h00, 32, 32'h000F0F0F);

        tick(20);
        check("pending_frames", 32'(fexp_q.size()), 32'd0);
        check("pending_cmds", 32'(cmd_q.size()), 32'd0);
        check("pending_frame_done", 32'(fd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
